// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single Dmem port between the core load/store path and a debug master.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of starvation-protected priority.
module dmem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic [2:0]    core_func3,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic [2:0]    dbg_func3,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [2:0]    mem_func3,
    input  logic [DW-1:0] mem_rd,
    output logic [1:0]    arb_owner
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // Handshake: a requester holds req and payload until it samples gnt=1 at a rising edge;
    // gnt high in a cycle means the access is performed in that same cycle.

    owner_e        owner_q, owner_d;
    logic          core_rvalid_q, core_rvalid_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          core_gnt_c, dbg_gnt_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_dbg_q, last_dbg_d;
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    // Grants are forced low during reset so nothing reaches memory or the read pipe.
    always_comb begin
        core_gnt_c = 1'b0;
        dbg_gnt_c  = 1'b0;
        if (!rst) begin
            if (core_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (last_dbg_q) core_gnt_c = 1'b1;
                else            dbg_gnt_c  = 1'b1;
`else
                if (starve_cnt_q == STARVE_MAX) dbg_gnt_c  = 1'b1;
                else                            core_gnt_c = 1'b1;
`endif
            end else begin
                core_gnt_c = core_req;
                dbg_gnt_c  = dbg_req;
            end
        end
    end

    always_comb begin
        owner_d       = OWN_NONE;
        core_rvalid_d = core_gnt_c & ~core_we;
        dbg_rvalid_d  = dbg_gnt_c & ~dbg_we;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        if (core_gnt_c) owner_d = OWN_CORE;
        if (dbg_gnt_c)  owner_d = OWN_DBG;
        if (core_rvalid_d) core_rdata_d = mem_rd;
        if (dbg_rvalid_d)  dbg_rdata_d  = mem_rd;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_dbg_d = last_dbg_q;
        if (core_gnt_c) last_dbg_d = 1'b0;
        if (dbg_gnt_c)  last_dbg_d = 1'b1;
`else
        starve_cnt_d = 4'd0;
        if (dbg_req && !dbg_gnt_c) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q       <= OWN_NONE;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_dbg_q    <= 1'b1;
`else
            starve_cnt_q  <= 4'd0;
`endif
        end else begin
            owner_q       <= owner_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_dbg_q    <= last_dbg_d;
`else
            starve_cnt_q  <= starve_cnt_d;
`endif
        end
    end

    // Address/data default to the core path when idle; only the write enable is gated.
    always_comb begin
        mem_a     = core_addr;
        mem_wd    = core_wdata;
        mem_func3 = core_func3;
        mem_we    = core_gnt_c & core_we;
        if (dbg_gnt_c) begin
            mem_a     = dbg_addr;
            mem_wd    = dbg_wdata;
            mem_func3 = dbg_func3;
            mem_we    = dbg_we;
        end
    end

    assign core_gnt    = core_gnt_c;
    assign dbg_gnt     = dbg_gnt_c;
    assign core_stall  = core_req & ~core_gnt_c;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign arb_owner   = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: grant/mux checks plus a read-return scoreboard.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic core_req, core_we, dbg_req, dbg_we;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata, mem_rd;
  logic [2:0] core_func3, dbg_func3;
  logic core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_we;
  logic [DW-1:0] core_rdata, dbg_rdata, mem_wd;
  logic [AW-1:0] mem_a;
  logic [2:0] mem_func3;
  logic [1:0] arb_owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [DW-1:0] core_exp_q[$];
  int            core_due_q[$];
  logic [DW-1:0] dbg_exp_q[$];
  int            dbg_due_q[$];

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_func3(mem_func3),
    .mem_rd(mem_rd), .arb_owner(arb_owner)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: read data must appear exactly in the cycle it is due
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_due_q.size() > 0 && core_due_q[0] == cyc) begin
        check("core_rvalid", {31'd0, core_rvalid}, 32'd1);
        check("core_rdata", core_rdata, core_exp_q.pop_front());
        void'(core_due_q.pop_front());
      end else begin
        check("core_rvalid_idle", {31'd0, core_rvalid}, 32'd0);
      end
      if (dbg_due_q.size() > 0 && dbg_due_q[0] == cyc) begin
        check("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
        void'(dbg_due_q.pop_front());
      end else begin
        check("dbg_rvalid_idle", {31'd0, dbg_rvalid}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [2:0] f3);
    core_req = req; core_we = we; core_addr = a; core_wdata = wd; core_func3 = f3;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [2:0] f3);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_func3 = f3;
  endtask

  task automatic expect_core_load(input logic [DW-1:0] d);
    core_exp_q.push_back(d);
    core_due_q.push_back(cyc + 1);
  endtask

  task automatic expect_dbg_load(input logic [DW-1:0] d);
    dbg_exp_q.push_back(d);
    dbg_due_q.push_back(cyc + 1);
  endtask

  initial begin
    logic exp_dbg;
    logic [DW-1:0] rd_val;

    // reset with both requesters active
    rst = 1'b1;
    mem_rd = 32'hCAFE_0001;
    drive_core(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    drive_dbg(1'b1, 1'b1, 32'h20, 32'h55, 3'b010);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
      check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      next_cycle();
      mon_en = 1'b1;
    end
    rst = 1'b0;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    settle();
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_owner", {30'd0, arb_owner}, 32'd0);
    next_cycle();

    // core load only
    mem_rd = 32'hDEAD_BEEF;
    drive_core(1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
    expect_core_load(32'hDEAD_BEEF);
    settle();
    check("ld_core_gnt", {31'd0, core_gnt}, 32'd1);
    check("ld_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("ld_mem_a", mem_a, 32'h40);
    check("ld_mem_we", {31'd0, mem_we}, 32'd0);
    check("ld_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    mem_rd = 32'h1111_2222;
    settle();
    check("owner_core", {30'd0, arb_owner}, 32'd1);
    next_cycle();

    // debug store only
    drive_dbg(1'b1, 1'b1, 32'h100, 32'h1234_5678, 3'b010);
    settle();
    check("st_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    check("st_core_gnt", {31'd0, core_gnt}, 32'd0);
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    check("st_mem_a", mem_a, 32'h100);
    check("st_mem_wd", mem_wd, 32'h1234_5678);
    check("st_mem_func3", {29'd0, mem_func3}, 32'd2);
    next_cycle();
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    settle();
    check("owner_dbg", {30'd0, arb_owner}, 32'd2);
    check("idle_mem_we", {31'd0, mem_we}, 32'd0);
    next_cycle();

    // back-to-back core loads
    mem_rd = 32'hA5A5_0001;
    drive_core(1'b1, 1'b0, 32'h80, 32'h0, 3'b010);
    expect_core_load(32'hA5A5_0001);
    next_cycle();
    mem_rd = 32'h5A5A_0002;
    drive_core(1'b1, 1'b0, 32'h84, 32'h0, 3'b010);
    expect_core_load(32'h5A5A_0002);
    next_cycle();

    // debug load, then core load must leave dbg_rdata untouched
    mem_rd = 32'h0BAD_F00D;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_dbg(1'b1, 1'b0, 32'h104, 32'h0, 3'b100);
    expect_dbg_load(32'h0BAD_F00D);
    settle();
    check("dld_mem_a", mem_a, 32'h104);
    check("dld_mem_func3", {29'd0, mem_func3}, 32'd4);
    next_cycle();
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    mem_rd = 32'h7777_8888;
    drive_core(1'b1, 1'b0, 32'h44, 32'h0, 3'b010);
    expect_core_load(32'h7777_8888);
    next_cycle();
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    settle();
    check("dbg_rdata_hold", dbg_rdata, 32'h0BAD_F00D);
    next_cycle();

    // reset asserted while a core load is requested: no read return
    rst = 1'b1;
    mem_rd = 32'hFFFF_0000;
    drive_core(1'b1, 1'b0, 32'h48, 32'h0, 3'b010);
    settle();
    check("rstop_core_gnt", {31'd0, core_gnt}, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    settle();
    check("rstop_core_rdata", core_rdata, 32'h0);
    next_cycle();

    // contention: both requesters load continuously
    drive_core(1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
    drive_dbg(1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
    for (int k = 0; k < 7; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_dbg = (k % 2) == 1;
`else
      exp_dbg = (k == 4);
`endif
      rd_val = $urandom_range(32'h7FFF_FFFF, 0);
      mem_rd = rd_val;
      if (exp_dbg) expect_dbg_load(rd_val);
      else         expect_core_load(rd_val);
      settle();
      check($sformatf("cont%0d_core_gnt", k), {31'd0, core_gnt}, {31'd0, ~exp_dbg});
      check($sformatf("cont%0d_dbg_gnt", k), {31'd0, dbg_gnt}, {31'd0, exp_dbg});
      check($sformatf("cont%0d_stall", k), {31'd0, core_stall}, {31'd0, exp_dbg});
      check($sformatf("cont%0d_mem_a", k), mem_a, exp_dbg ? 32'h300 : 32'h200);
      next_cycle();
    end
    drive_core(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) next_cycle();

    check("core_queue_drained", core_exp_q.size(), 32'd0);
    check("dbg_queue_drained", dbg_exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (Dmem: we, a, wd, func3 → rd) between two requesters: the core load/store path and a debug/program-loader master.
- Sits between the core's load/store datapath and Dmem. The core uses its stall output to hold the current instruction while the debug master owns the port.
- Default policy is fixed priority with starvation protection. Read data is returned registered, one cycle after grant.

Parameters:
- AW, 32, address width of both requesters and the memory port.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles a pending debug request may lose before it is force-granted (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- core_req  input  1  core requests a memory access this cycle.
- core_we  input  1  1 = store, 0 = load.
- core_addr  input  AW  byte address.
- core_wdata  input  DW  store data.
- core_func3  input  3  access size/sign (instr[14:12] encoding).
- core_gnt  output  1  combinational; access accepted this cycle.
- core_stall  output  1  core_req & ~core_gnt.
- core_rvalid  output  1  registered; load data valid.
- core_rdata  output  DW  registered load data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3  input  1/1/AW/DW/3  same meaning for the debug master.
- dbg_gnt  output  1  combinational grant.
- dbg_rvalid  output  1  registered read valid.
- dbg_rdata  output  DW  registered read data.
- mem_we  output  1  Dmem write enable.
- mem_a  output  AW  Dmem address.
- mem_wd  output  DW  Dmem write data.
- mem_func3  output  3  Dmem func3.
- mem_rd  input  DW  Dmem combinational read data.

Behaviour:
- One transaction per grant; each grant is one cycle.
- Requesters hold req and their payload stable until they see gnt=1, sampled at the rising edge.
- At most one of core_gnt/dbg_gnt is high in any cycle. Grants are a combinational function of the req inputs and registered state.
- Owner state (registered): OWN_NONE, OWN_CORE, OWN_DBG = who was granted in the previous cycle. Next state is the granted requester, or OWN_NONE if there was no grant.
- Grant rule (default): only one requester → it is granted. Both requesting → core wins unless starve_cnt == STARVE_LIMIT, in which case dbg wins.
- starve_cnt (4 bits):
  - +1 each cycle dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on dbg_gnt=1 or dbg_req=0.
- Memory mux:
  - mem_a/mem_wd/mem_func3 come from the granted requester; they come from the core when no grant is active.
  - mem_we = granted requester's we & gnt; it is 0 with no grant.
- Read return:
  - If a load is granted in cycle N, mem_rd is captured into that requester's rdata at the end of cycle N.
  - The requester's rvalid=1 in cycle N+1 for exactly one cycle.
  - rdata holds its value until the next load for that requester.
- Stores produce no rvalid.
- Back-to-back loads from the same requester in N and N+1 give rvalid high in N+1 and N+2 with the correct respective data.
- Reset: while rst=1, both gnt=0 and mem_we=0. At the next edge after rst: rvalid=0, rdata=0, owner=OWN_NONE, starve_cnt=0.
  - A load granted in the cycle rst is asserted produces no rvalid.
- Requests arriving on the first cycle after rst deasserts are arbitrated normally.

Optional Feature:
- Macro DMEM_ARB_ROUND_ROBIN_EN.
  - Defined: on contention, grant goes to the requester not granted most recently (last_winner register, reset to dbg so core wins the first tie). starve_cnt is not implemented.
  - Not defined: fixed priority with starvation counter, as in Behaviour.
- Single-requester behaviour, latency and read return are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high → gnt=0, mem_we=0 throughout. After release: rvalid=0, rdata=0.
- Core load only: mem_rd=0xDEADBEEF, core_req=1, core_we=0, core_addr=0x40 in cycle N → core_gnt=1 and mem_a=0x40 in N; core_rvalid=1 and core_rdata=0xDEADBEEF in N+1; core_rvalid=0 in N+2.
- Debug store only: dbg_we=1, addr=0x100, wdata=0x12345678, func3=010 → dbg_gnt=1, mem_we=1, mem_wd=0x12345678, mem_func3=010 in the same cycle; no dbg_rvalid.
- Starvation (default build, STARVE_LIMIT=4): both req continuously → core granted 4 cycles, dbg granted cycle 5, core cycle 6. core_stall=1 only in cycle 5.
- Round robin (DMEM_ARB_ROUND_ROBIN_EN): both req continuously → grants alternate core, dbg, core, dbg starting with core.
- Reset mid-op: core load granted in the same cycle rst=1 → core_rvalid stays 0 next cycle.
